// File: rtl/alu_issue_queue.sv
// Command FIFO feeding a combinational ALU, with a registered result stage.
// The head entry drives the ALU; its result is captured when the output register is free.
module alu_issue_queue #(
  parameter int unsigned N     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N-1:0]             in_a,
  input  logic [N-1:0]             in_b,
  input  logic [2:0]               in_op,
  output logic [N-1:0]             A,
  output logic [N-1:0]             B,
  output logic [2:0]               alu_control,
  input  logic [N-1:0]             result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N-1:0]             out_result,
  output logic [2:0]               out_op,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = 2 * N + 3;

  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          out_valid_q, out_valid_d;
  logic [N-1:0]  out_result_q, out_result_d;
  logic [2:0]    out_op_q, out_op_d;

  logic          not_empty;
  logic          push;
  logic          issue;
  logic [EW-1:0] head;

  // in_ready depends only on occupancy, never on a same-cycle pop.
  always_comb begin
    not_empty = (count_q != '0);
    in_ready  = (count_q < CW'(DEPTH));
    push      = in_valid && in_ready;
    issue     = not_empty && (!out_valid_q || out_ready);
    head      = mem_q[rd_ptr_q];
    {alu_control, B, A} = not_empty ? head : '0;
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {in_op, in_b, in_a};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (issue) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push && !issue) begin
      count_d = count_q + CW'(1);
    end else if (issue && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_op_d     = out_op_q;
    if (issue) begin
      out_valid_d  = 1'b1;
      out_result_d = result;
      out_op_d     = head[EW-1 -: 3];
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_op_q     <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_op_q     <= out_op_d;
    end
  end

  // Storage needs no reset: entries are only visible while count is nonzero.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_op     = out_op_q;
  assign count      = count_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Self-checking bench for alu_issue_queue: directed scenarios plus random traffic,
// compared against a queue-based model. The ALU is modelled as A + B.
module tb_alu_issue_queue;

  localparam int unsigned N     = 8;
  localparam int unsigned DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_a, in_b;
  logic [2:0]   in_op;
  logic [N-1:0] A, B;
  logic [2:0]   alu_control;
  logic [N-1:0] result;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_result;
  logic [2:0]   out_op;
  logic [2:0]   count;

  alu_issue_queue #(.N(N), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .A          (A),
    .B          (B),
    .alu_control(alu_control),
    .result     (result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_op     (out_op),
    .count      (count)
  );

  assign result = A + B;

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [2:0]   op;
  } cmd_t;

  cmd_t         mq[$];
  logic         m_ov;
  logic [N-1:0] m_res;
  logic [2:0]   m_op;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_model();
    check_eq("count", 32'(count), 32'(mq.size()));
    check_eq("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
    check_eq("out_valid", 32'(out_valid), 32'(m_ov));
    check_eq("out_result", 32'(out_result), 32'(m_res));
    check_eq("out_op", 32'(out_op), 32'(m_op));
    if (mq.size() > 0) begin
      check_eq("A", 32'(A), 32'(mq[0].a));
      check_eq("B", 32'(B), 32'(mq[0].b));
      check_eq("alu_control", 32'(alu_control), 32'(mq[0].op));
    end else begin
      check_eq("A_empty", 32'(A), 32'd0);
      check_eq("B_empty", 32'(B), 32'd0);
      check_eq("op_empty", 32'(alu_control), 32'd0);
    end
  endtask

  // One clock: drive inputs, advance the model across the edge, then compare.
  task automatic step(input logic r, input logic iv, input logic [N-1:0] a,
                      input logic [N-1:0] b, input logic [2:0] op, input logic ordy,
                      output logic acc);
    logic do_push, do_issue;
    cmd_t c;
    rst = r; in_valid = iv; in_a = a; in_b = b; in_op = op; out_ready = ordy;
    do_push  = !r && iv && (mq.size() < DEPTH);
    do_issue = !r && (mq.size() > 0) && (!m_ov || ordy);
    acc = do_push;
    @(posedge clk);
    #1;
    if (r) begin
      mq.delete();
      m_ov = 1'b0; m_res = '0; m_op = '0;
    end else begin
      if (do_issue) begin
        c = mq.pop_front();
        m_res = c.a + c.b;
        m_op  = c.op;
        m_ov  = 1'b1;
      end else if (ordy) begin
        m_ov = 1'b0;
      end
      if (do_push) mq.push_back('{a: a, b: b, op: op});
    end
    check_model();
  endtask

  logic         acc;
  logic [N-1:0] held_res;
  logic [2:0]   held_op;
  cmd_t         fill[6];
  int           idx;

  initial begin
    m_ov = 1'b0; m_res = '0; m_op = '0;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b0;

    // Reset for two cycles.
    step(1, 0, 0, 0, 0, 0, acc);
    step(1, 0, 0, 0, 0, 0, acc);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_count", 32'(count), 32'd0);

    // Single command: 0xF6 + 0x0A wraps to 0x00.
    step(0, 1, 8'hF6, 8'h0A, 3'd3, 1, acc);
    check_eq("single_A", 32'(A), 32'hF6);
    check_eq("single_no_bypass", 32'(out_valid), 32'd0);
    step(0, 0, 0, 0, 0, 1, acc);
    check_eq("single_valid", 32'(out_valid), 32'd1);
    check_eq("single_result", 32'(out_result), 32'h00);
    check_eq("single_op", 32'(out_op), 32'd3);
    step(0, 0, 0, 0, 0, 1, acc);
    check_eq("single_clear", 32'(out_valid), 32'd0);

    // Fill with the output stalled: first command captured, next four queued.
    fill[0] = '{a: 8'h10, b: 8'h20, op: 3'd1};
    fill[1] = '{a: 8'h21, b: 8'h37, op: 3'd2};
    fill[2] = '{a: 8'h02, b: 8'h01, op: 3'd4};
    fill[3] = '{a: 8'h40, b: 8'h05, op: 3'd5};
    fill[4] = '{a: 8'h7F, b: 8'h01, op: 3'd6};
    fill[5] = '{a: 8'hAA, b: 8'h11, op: 3'd7};
    idx = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 1, fill[idx].a, fill[idx].b, fill[idx].op, 0, acc);
      if (acc && idx < 5) idx++;
    end
    check_eq("fill_count", 32'(count), 32'd4);
    check_eq("fill_ready", 32'(in_ready), 32'd0);
    check_eq("fill_idx", 32'(idx), 32'd5);
    check_eq("fill_captured", 32'(out_result), 32'h30);

    // Backpressure: output must hold for 10 cycles.
    held_res = out_result;
    held_op  = out_op;
    for (int i = 0; i < 10; i++) step(0, 1, fill[5].a, fill[5].b, fill[5].op, 0, acc);
    check_eq("bp_result", 32'(out_result), 32'(held_res));
    check_eq("bp_op", 32'(out_op), 32'(held_op));
    step(0, 0, 0, 0, 0, 1, acc);
    check_eq("bp_first", 32'(out_result), 32'h58);
    step(0, 0, 0, 0, 0, 1, acc);
    check_eq("bp_second", 32'(out_result), 32'h03);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1, acc);
    check_eq("drained", 32'(count), 32'd0);

    // Reach count=2 with the output stalled, then push and pop every cycle across wraps.
    for (int i = 0; i < 3; i++) step(0, 1, 8'(i), 8'(3 * i), 3'(i), 0, acc);
    check_eq("ss_count0", 32'(count), 32'd2);
    for (int i = 0; i < 3 * DEPTH; i++) begin
      step(0, 1, 8'($urandom), 8'($urandom), 3'($urandom), 1, acc);
      check_eq("ss_count", 32'(count), 32'd2);
    end
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1, acc);

    // Mid-operation reset with count=3 and a captured result.
    for (int i = 0; i < 4; i++) step(0, 1, 8'(i + 5), 8'(i), 3'(i), 0, acc);
    check_eq("mr_count_pre", 32'(count), 32'd3);
    check_eq("mr_valid_pre", 32'(out_valid), 32'd1);
    step(1, 1, 8'h55, 8'h55, 3'd2, 1, acc);
    check_eq("mr_count", 32'(count), 32'd0);
    check_eq("mr_valid", 32'(out_valid), 32'd0);
    check_eq("mr_result", 32'(out_result), 32'd0);
    step(0, 1, 8'h0F, 8'h22, 3'd1, 1, acc);
    step(0, 0, 0, 0, 0, 1, acc);
    check_eq("mr_next", 32'(out_result), 32'h31);

    // Random traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) != 0), 8'($urandom),
           8'($urandom), 3'($urandom), ($urandom_range(0, 2) != 0), acc);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
